// File: rtl/wb_uart16550_lite_pkg.sv
// wb_uart16550_lite_pkg: register offsets, bit indices, IIR codes and FSM states for the UART
package wb_uart16550_lite_pkg;
  localparam logic [2:0] RBR_THR_DLL = 3'd0, IER_DLM = 3'd1, IIR_FCR = 3'd2, LCR = 3'd3, LSR = 3'd5;
  localparam int LSR_DR = 0, LSR_OE = 1, LSR_FE = 3, LSR_THRE = 5, LSR_TEMT = 6;
  localparam logic [7:0] IIR_NONE = 8'h01, IIR_THRE = 8'h02, IIR_RDA = 8'h04;
  localparam int FCR_RXCLR = 1, FCR_TXCLR = 2;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
endpackage

// File: rtl/wb_uart16550_lite_fifo.sv
// wb_uart16550_lite_fifo: byte FIFO with push/pop/clear; clear wins, push accepted when full if popped
module wb_uart16550_lite_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/wb_uart16550_lite.sv
// wb_uart16550_lite: Wishbone 16550-subset UART, 8N1, 16x oversampling, TX/RX FIFOs
module wb_uart16550_lite
  import wb_uart16550_lite_pkg::*;
#(
  parameter int          FIFO_DEPTH    = 16,
  parameter logic [15:0] DIVISOR_RESET = 16'd0
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic [2:0] wb_adr_i,
  input  logic [7:0] wb_dat_i,
  output logic [7:0] wb_dat_o,
  input  logic       wb_we_i,
  input  logic       wb_stb_i,
  input  logic       wb_cyc_i,
  output logic       wb_ack_o,
  output logic       int_o,
  output logic       txd_o,
  input  logic       rxd_i
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  logic [7:0] lcr, rdata, lsr, iir, tx_dout, rx_dout, tx_shift, rx_shift;
  logic [1:0] ier;
  logic [15:0] div, baud_cnt;
  logic [3:0] tx_tcnt, rx_tcnt;
  logic [2:0] tx_bit, rx_bit;
  logic [CW-1:0] tx_count, rx_count;
  logic access, rd, wr, dlab, reg0, lsr_rd, tick, oe, fe, dr, thre, temt;
  logic rx_pop, tx_push, rx_clear, tx_clear, tx_pop, tx_avail, tx_end;
  logic rx_mid, rx_push, oe_set, fe_set, rx_meta, rx_sync;
  logic rx_full, rx_empty, tx_full, tx_empty, unused_ok;
  tx_state_t tx_state, tx_next;
  rx_state_t rx_state, rx_next;
  assign access = wb_cyc_i && wb_stb_i && !wb_ack_o;
  assign rd = access && !wb_we_i;
  assign wr = access && wb_we_i;
  assign dlab = lcr[7];
  assign reg0 = wb_adr_i == RBR_THR_DLL && !dlab;
  assign lsr_rd = rd && wb_adr_i == LSR;
  assign rx_pop = rd && reg0;
  assign tx_push = wr && reg0;
  assign rx_clear = wr && wb_adr_i == IIR_FCR && wb_dat_i[FCR_RXCLR];
  assign tx_clear = wr && wb_adr_i == IIR_FCR && wb_dat_i[FCR_TXCLR];
  assign dr = !rx_empty;
  assign thre = tx_empty;
  assign temt = thre && tx_state == TX_IDLE;
  assign tick = baud_cnt == '0 && div != '0;
  assign iir = ier[0] && dr ? IIR_RDA : ier[1] && thre ? IIR_THRE : IIR_NONE;
  assign unused_ok = ^{tx_count, rx_count, tx_full};
  always_comb begin
    lsr = '0;
    lsr[LSR_DR] = dr;
    lsr[LSR_OE] = oe;
    lsr[LSR_FE] = fe;
    lsr[LSR_THRE] = thre;
    lsr[LSR_TEMT] = temt;
  end
  always_comb begin
    rdata = '0;
    case (wb_adr_i)
      RBR_THR_DLL: rdata = dlab ? div[7:0] : rx_empty ? 8'h00 : rx_dout;
      IER_DLM:     rdata = dlab ? div[15:8] : {6'b0, ier};
      IIR_FCR:     rdata = iir;
      LCR:         rdata = lcr;
      LSR:         rdata = lsr;
      default:     rdata = '0;
    endcase
  end
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
      int_o <= 1'b0;
      ier <= '0;
      lcr <= '0;
      div <= DIVISOR_RESET;
      oe <= 1'b0;
      fe <= 1'b0;
      baud_cnt <= '0;
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      wb_ack_o <= access;
      if (rd) wb_dat_o <= rdata;
      int_o <= (ier[0] && dr) || (ier[1] && thre);
      if (wr && wb_adr_i == LCR) lcr <= wb_dat_i;
      if (wr && wb_adr_i == RBR_THR_DLL && dlab) div[7:0] <= wb_dat_i;
      if (wr && wb_adr_i == IER_DLM && dlab) div[15:8] <= wb_dat_i;
      if (wr && wb_adr_i == IER_DLM && !dlab) ier <= wb_dat_i[1:0];
      oe <= oe_set || (oe && !lsr_rd);
      fe <= fe_set || (fe && !lsr_rd);
      baud_cnt <= baud_cnt != '0 ? baud_cnt - 16'd1 : div != '0 ? div - 16'd1 : '0;
      rx_meta <= rxd_i;
      rx_sync <= rx_meta;
    end
  end
  assign tx_avail = !tx_empty && !tx_clear;
  assign tx_end = tick && tx_tcnt == 4'd15;
  assign tx_pop = tick && tx_avail && (tx_state == TX_IDLE || (tx_state == TX_STOP && tx_tcnt == 4'd15));
  always_ff @(posedge wb_clk_i)
    tx_state <= wb_rst_i ? TX_IDLE : tx_next;
  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      TX_IDLE:  if (tx_pop) tx_next = TX_START;
      TX_START: if (tx_end) tx_next = TX_DATA;
      TX_DATA:  if (tx_end && tx_bit == 3'd7) tx_next = TX_STOP;
      TX_STOP:  if (tx_end) tx_next = tx_pop ? TX_START : TX_IDLE;
    endcase
  end
  always_comb
    txd_o = tx_state == TX_START ? 1'b0 : tx_state == TX_DATA ? tx_shift[0] : 1'b1;
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      tx_tcnt <= '0;
      tx_bit <= '0;
      tx_shift <= '0;
    end else if (tx_pop) begin
      tx_shift <= tx_dout;
      tx_tcnt <= '0;
      tx_bit <= '0;
    end else if (tick && tx_state != TX_IDLE) begin
      tx_tcnt <= tx_tcnt + 4'd1;
      if (tx_state == TX_DATA && tx_tcnt == 4'd15) begin
        tx_shift <= tx_shift >> 1;
        tx_bit <= tx_bit + 3'd1;
      end
    end
  end
  assign rx_mid = tick && rx_tcnt == (rx_state == RX_START ? 4'd7 : 4'd15);
  assign rx_push = rx_mid && rx_state == RX_STOP && rx_sync;
  assign oe_set = rx_push && rx_full && !rx_pop && !rx_clear;
  assign fe_set = rx_mid && rx_state == RX_STOP && !rx_sync;
  always_ff @(posedge wb_clk_i)
    rx_state <= wb_rst_i ? RX_IDLE : rx_next;
  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE:  if (tick && !rx_sync) rx_next = RX_START;
      RX_START: if (rx_mid) rx_next = rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_mid && rx_bit == 3'd7) rx_next = RX_STOP;
      RX_STOP:  if (rx_mid) rx_next = RX_IDLE;
    endcase
  end
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      rx_tcnt <= '0;
      rx_bit <= '0;
      rx_shift <= '0;
    end else begin
      rx_tcnt <= rx_next != rx_state ? 4'd0 : tick ? rx_tcnt + 4'd1 : rx_tcnt;
      if (rx_state == RX_START) rx_bit <= '0;
      if (rx_mid && rx_state == RX_DATA) begin
        rx_shift <= {rx_sync, rx_shift[7:1]};
        rx_bit <= rx_bit + 3'd1;
      end
    end
  end
  wb_uart16550_lite_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(wb_clk_i), .rst(wb_rst_i), .push(tx_push), .pop(tx_pop), .clear(tx_clear),
    .din(wb_dat_i), .dout(tx_dout), .full(tx_full), .empty(tx_empty), .count(tx_count)
  );
  wb_uart16550_lite_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(wb_clk_i), .rst(wb_rst_i), .push(rx_push), .pop(rx_pop), .clear(rx_clear),
    .din(rx_shift), .dout(rx_dout), .full(rx_full), .empty(rx_empty), .count(rx_count)
  );
endmodule

// File: tb/tb_wb_uart16550_lite.sv
// tb_wb_uart16550_lite: directed self-checking bench for the Wishbone 16550-lite UART
module tb_wb_uart16550_lite;
  logic clk = 1'b0, rst = 1'b1;
  logic [2:0] adr = '0;
  logic [7:0] dat_w = '0, dat_r;
  logic we = 1'b0, stb = 1'b0, cyc = 1'b0, ack, irq, txd, rxd, rxd_drv = 1'b1, loop = 1'b0;
  int errors = 0, checks = 0;
  assign rxd = loop ? txd : rxd_drv;
  always #5 clk = ~clk;
  wb_uart16550_lite #(.FIFO_DEPTH(16), .DIVISOR_RESET(16'd0)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_dat_i(dat_w), .wb_dat_o(dat_r),
    .wb_we_i(we), .wb_stb_i(stb), .wb_cyc_i(cyc), .wb_ack_o(ack), .int_o(irq),
    .txd_o(txd), .rxd_i(rxd)
  );
  task automatic bus(input logic [2:0] a, input logic w, input logic [7:0] d, output logic [7:0] q);
    int n;
    @(posedge clk); #1;
    adr = a; we = w; dat_w = d; cyc = 1'b1; stb = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!ack && n < 8);
    q = dat_r;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    if (!ack) begin
      checks++; errors++;
      $display("FAIL bus_ack adr=%0d got no ack within 8 cycles", a);
    end
  endtask
  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    logic [7:0] q;
    bus(a, 1'b1, d, q);
  endtask
  task automatic rd(input logic [2:0] a, output logic [7:0] q);
    bus(a, 1'b0, 8'h00, q);
  endtask
  task automatic send_byte(input logic [7:0] b, input logic stop);
    rxd_drv = 1'b0; repeat (32) @(posedge clk);
    for (int i = 0; i < 8; i++) begin rxd_drv = b[i]; repeat (32) @(posedge clk); end
    rxd_drv = stop; repeat (32) @(posedge clk);
    rxd_drv = 1'b1;
  endtask
  task automatic test_reset;
    logic [7:0] q;
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    checks++; if (txd !== 1'b1 || irq !== 1'b0 || ack !== 1'b0 || dat_r !== 8'h00) begin errors++; $display("FAIL reset_pins txd=%b int=%b ack=%b dat=%h exp 1 0 0 00", txd, irq, ack, dat_r); end
    rd(3'd5, q); checks++; if (q !== 8'h60) begin errors++; $display("FAIL reset_lsr got %h exp 60", q); end
    rd(3'd2, q); checks++; if (q !== 8'h01) begin errors++; $display("FAIL reset_iir got %h exp 01", q); end
    wr(3'd3, 8'h80);
    rd(3'd0, q); checks++; if (q !== 8'h00) begin errors++; $display("FAIL reset_dll got %h exp 00", q); end
    rd(3'd1, q); checks++; if (q !== 8'h00) begin errors++; $display("FAIL reset_dlm got %h exp 00", q); end
    wr(3'd7, 8'hFF);
    rd(3'd7, q); checks++; if (q !== 8'h00) begin errors++; $display("FAIL scratch_reg7 got %h exp 00", q); end
  endtask
  task automatic test_tx_frame;
    logic [7:0] q, exp_byte;
    int n;
    exp_byte = 8'hA5;
    wr(3'd0, 8'h02); wr(3'd1, 8'h00);
    rd(3'd0, q); checks++; if (q !== 8'h02) begin errors++; $display("FAIL dll_readback got %h exp 02", q); end
    wr(3'd3, 8'h03);
    rd(3'd3, q); checks++; if (q !== 8'h03) begin errors++; $display("FAIL lcr_readback got %h exp 03", q); end
    wr(3'd0, exp_byte);
    n = 0;
    while (txd !== 1'b0 && n < 200) begin @(posedge clk); #1; n++; end
    checks++; if (txd !== 1'b0) begin errors++; $display("FAIL tx_start_seen txd=%b exp 0 within 200 cycles", txd); end
    n = 0;
    do begin @(posedge clk); #1; n++; end while (txd === 1'b0 && n < 100);
    checks++; if (n !== 32) begin errors++; $display("FAIL tx_start_width got %0d cycles exp 32", n); end
    repeat (16) @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      checks++; if (txd !== exp_byte[i]) begin errors++; $display("FAIL tx_bit%0d got %b exp %b", i, txd, exp_byte[i]); end
      repeat (32) @(posedge clk); #1;
    end
    checks++; if (txd !== 1'b1) begin errors++; $display("FAIL tx_stop got %b exp 1", txd); end
    rd(3'd5, q); checks++; if (q !== 8'h20) begin errors++; $display("FAIL lsr_in_stop got %h exp 20", q); end
    repeat (20) @(posedge clk);
    rd(3'd5, q); checks++; if (q !== 8'h60) begin errors++; $display("FAIL lsr_after_tx got %h exp 60", q); end
  endtask
  task automatic test_loopback;
    logic [7:0] q;
    loop = 1'b1;
    wr(3'd0, 8'h3C);
    repeat (400) @(posedge clk);
    rd(3'd5, q); checks++; if (q !== 8'h61) begin errors++; $display("FAIL loop_lsr_dr got %h exp 61", q); end
    rd(3'd0, q); checks++; if (q !== 8'h3C) begin errors++; $display("FAIL loop_rbr got %h exp 3c", q); end
    rd(3'd5, q); checks++; if (q !== 8'h60) begin errors++; $display("FAIL loop_lsr_empty got %h exp 60", q); end
    rd(3'd0, q); checks++; if (q !== 8'h00) begin errors++; $display("FAIL rbr_empty got %h exp 00", q); end
    loop = 1'b0;
  endtask
  task automatic test_overrun;
    logic [7:0] q;
    for (int i = 0; i < 17; i++) send_byte(8'(i), 1'b1);
    repeat (8) @(posedge clk);
    rd(3'd5, q); checks++; if (q !== 8'h63) begin errors++; $display("FAIL ovr_lsr got %h exp 63", q); end
    rd(3'd5, q); checks++; if (q !== 8'h61) begin errors++; $display("FAIL ovr_lsr_cleared got %h exp 61", q); end
    for (int i = 0; i < 16; i++) begin
      rd(3'd0, q); checks++; if (q !== 8'(i)) begin errors++; $display("FAIL ovr_rbr%0d got %h exp %h", i, q, 8'(i)); end
    end
    rd(3'd5, q); checks++; if (q !== 8'h60) begin errors++; $display("FAIL ovr_drained got %h exp 60", q); end
  endtask
  task automatic test_framing_glitch;
    logic [7:0] q;
    send_byte(8'h55, 1'b0);
    repeat (64) @(posedge clk);
    rd(3'd5, q); checks++; if (q !== 8'h68) begin errors++; $display("FAIL fe_lsr got %h exp 68", q); end
    rd(3'd5, q); checks++; if (q !== 8'h60) begin errors++; $display("FAIL fe_cleared got %h exp 60", q); end
    rxd_drv = 1'b0; repeat (8) @(posedge clk);
    rxd_drv = 1'b1; repeat (400) @(posedge clk);
    rd(3'd5, q); checks++; if (q !== 8'h60) begin errors++; $display("FAIL glitch_lsr got %h exp 60", q); end
    send_byte(8'h9E, 1'b1);
    repeat (8) @(posedge clk);
    wr(3'd2, 8'h02);
    rd(3'd5, q); checks++; if (q !== 8'h60) begin errors++; $display("FAIL fcr_rx_clear got %h exp 60", q); end
  endtask
  task automatic test_interrupt;
    logic [7:0] q;
    loop = 1'b1;
    wr(3'd1, 8'h03);
    @(posedge clk); #1;
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL int_thre got %b exp 1", irq); end
    rd(3'd2, q); checks++; if (q !== 8'h02) begin errors++; $display("FAIL iir_thre got %h exp 02", q); end
    wr(3'd0, 8'h11);
    repeat (400) @(posedge clk);
    rd(3'd2, q); checks++; if (q !== 8'h04) begin errors++; $display("FAIL iir_rda got %h exp 04", q); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL int_rda got %b exp 1", irq); end
    rd(3'd0, q); checks++; if (q !== 8'h11) begin errors++; $display("FAIL int_rbr got %h exp 11", q); end
    rd(3'd2, q); checks++; if (q !== 8'h02) begin errors++; $display("FAIL iir_after_pop got %h exp 02", q); end
    wr(3'd1, 8'h00);
    repeat (2) @(posedge clk); #1;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL int_off got %b exp 0", irq); end
    rd(3'd2, q); checks++; if (q !== 8'h01) begin errors++; $display("FAIL iir_none got %h exp 01", q); end
    loop = 1'b0;
  endtask
  initial begin
    test_reset;
    test_tx_frame;
    test_loopback;
    test_overrun;
    test_framing_glitch;
    test_interrupt;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/wb_uart16550_lite.md
Name: wb_uart16550_lite

Overview:
- Wishbone-slave UART responder implementing the 16550 register subset used by the wb_uart16550 firmware driver: init programs the divisor, write pushes THR, read pops RBR.
- Sits on the peripheral Wishbone bus at the driver's base address and drives the serial pins.
- Fixed 8N1 framing, 16x oversampling, independent TX and RX FIFOs.

Parameters:
- FIFO_DEPTH, 16, entries per TX/RX FIFO; power of two, >=2.
- DIVISOR_RESET, 16'd0, reset value of {DLM,DLL}; 0 halts baud ticks.

Ports:
- wb_clk_i  in  1  sole clock.
- wb_rst_i  in  1  synchronous, active-high reset.
- wb_adr_i  in  3  register offset.
- wb_dat_i  in  8  write data.
- wb_dat_o  out 8  read data; valid with wb_ack_o.
- wb_we_i   in  1  write enable.
- wb_stb_i  in  1  strobe.
- wb_cyc_i  in  1  cycle.
- wb_ack_o  out 1  one-cycle acknowledge.
- int_o     out 1  level interrupt.
- txd_o     out 1  serial out, idle high.
- rxd_i     in  1  serial in, asynchronous.

Behaviour:
- Reset values: wb_ack_o=0, wb_dat_o=0, int_o=0, txd_o=1. IER=0, LCR=0, divisor=DIVISOR_RESET, both FIFOs empty, OE=FE=0, TX/RX FSMs idle, synchronizer flops=1.
- Bus: an access is cyc&stb&!ack. ack asserts the next cycle for exactly one cycle, so there are no back-to-back acks. Read data and side effects (pop, flag clear) happen on the access cycle, once per ack.
- Register map, DLAB=LCR[7]:
  - 0, DLAB=0: read RBR pops RX FIFO (0x00 if empty, no pop); write THR pushes TX FIFO, dropped silently if full.
  - 0, DLAB=1: DLL.
  - 1, DLAB=0: IER[1:0] (ERBFI, ETBEI); upper bits read 0.
  - 1, DLAB=1: DLM.
  - 2: read IIR = 0x04 if ERBFI&DR, else 0x02 if ETBEI&THRE, else 0x01. Write FCR: bit1 clears RX FIFO, bit2 clears TX FIFO; other bits ignored.
  - 3: LCR, full 8-bit R/W; only bit7 has effect.
  - 5: LSR read-only: bit0 DR=RX non-empty, bit1 OE, bit3 FE, bit5 THRE=TX FIFO empty, bit6 TEMT=THRE&TX idle; other bits 0. Reading LSR clears OE and FE.
  - 4, 6, 7: read 0, writes ignored.
- int_o = (ERBFI&DR) | (ETBEI&THRE), registered (1-cycle lag).
- Baud: 16-bit down-counter. Reloads divisor-1 when it reaches 0 and emits a one-cycle tick. Divisor 1 gives a tick every cycle; divisor 0 gives no ticks and holds both FSMs. A divisor write takes effect at the next reload.
- TX FSM IDLE->START->DATA->STOP->IDLE; each bit lasts 16 ticks, LSB first.
  - IDLE pops TX FIFO when non-empty.
  - STOP returns to IDLE, or chains straight into the next START if the FIFO is non-empty.
- RX FSM:
  - rxd_i passes a 2-flop synchronizer.
  - IDLE->START on synchronized 0. START samples at tick 8: 1 returns to IDLE (glitch), 0 moves to DATA.
  - DATA samples every 16 ticks for 8 bits, then STOP samples mid-bit.
  - Stop bit 1: push byte, or set OE and discard if FIFO full. Stop bit 0: set FE, discard byte. Either way return to IDLE.
- Simultaneous events:
  - RBR pop + RX push same cycle: both happen, count unchanged. Same for THR push + TX pop.
  - Push when FIFO full but popped that same cycle: push accepted.
  - FCR clear + push same cycle: clear wins, FIFO empty. FCR TX clear does not abort a frame in flight.
  - LSR read + new OE/FE same cycle: set wins.
- Reset mid-frame aborts immediately: txd_o=1, partial RX byte lost.

Decomposition:
- Package wb_uart16550_lite_pkg holds:
  - register offset localparams (RBR_THR_DLL=0 … LSR=5);
  - LSR bit indices;
  - IIR codes 0x01/0x02/0x04;
  - FCR bit indices;
  - TX/RX state enums.
- Sub-module wb_uart16550_lite_fifo: synchronous FIFO with DEPTH parameter, push/pop/clear, full/empty/count. Instantiated twice.

Test Plan:
- Reset -> txd_o=1, int_o=0; LSR reads 0x60, IIR reads 0x01, DLL/DLM read DIVISOR_RESET.
- Write LCR=0x80, DLL=0x02, DLM=0x00, LCR=0x03, THR=0xA5 -> txd_o shows start 0, then 1,0,1,0,0,1,0,1, then stop 1, each bit 32 cycles (320 total). LSR bit5 =1 once the FIFO pops, bit6 =1 after stop.
- txd_o looped to rxd_i, THR=0x3C -> after the frame LSR=0x61, RBR=0x3C, then LSR=0x60. RBR on empty FIFO returns 0x00.
- Drive 17 serial bytes 0x00..0x10 with no reads -> LSR bit1=1, first LSR read clears OE. 16 RBR reads return 0x00..0x0F, then DR=0.
- Frame 0x55 with stop bit 0 -> LSR bit3=1, DR=0; start glitch shorter than 8 ticks -> no byte, no flag.
- IER=0x03, loopback idle -> int_o=1, IIR=0x02. Write THR=0x11 -> IIR=0x04 after RX completes (RX priority). Read RBR -> IIR=0x02. IER=0 -> int_o=0.
